// File: rtl/multicycle_pkg.sv
// Shared constants for the multi-cycle control unit.
// Holds opcode/funct3 values, ALU codes, ALUSrcB codes and the FSM state enum.
package multicycle_pkg;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] F3_LDSD = 3'b011;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [3:0] ALU_ADDR = 4'b0000;
    localparam logic [3:0] ALU_BEQ  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_ORI  = 4'b0111;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_TRAP
    } state_t;

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational instruction-field decoder: Opcode/Funct3/Funct7b5 -> ALU op + legal flag.
// Ports: i_opcode, i_funct3, i_funct7b5 in; o_op (4b), o_legal out.
module alu_op_decode
    import multicycle_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [3:0] o_op,
    output logic       o_legal
);

    always_comb begin
        o_op    = ALU_ADDR;
        o_legal = 1'b0;
        case (i_opcode)
            OP_LD, OP_SD: begin
                o_op    = ALU_ADDR;
                o_legal = (i_funct3 == F3_LDSD);
            end
            OP_BR: begin
                o_op    = ALU_BEQ;
                o_legal = (i_funct3 == F3_BEQ);
            end
            OP_I: begin
                o_op    = ALU_ORI;
                o_legal = (i_funct3 == F3_OR);
            end
            OP_R: begin
                case (i_funct3)
                    F3_ADD: begin
                        o_op    = i_funct7b5 ? ALU_SUB : ALU_ADD;
                        o_legal = 1'b1;
                    end
                    F3_SLL: begin
                        o_op    = ALU_SLL;
                        o_legal = !i_funct7b5;
                    end
                    F3_OR: begin
                        o_op    = ALU_OR;
                        o_legal = !i_funct7b5;
                    end
                    F3_AND: begin
                        o_op    = ALU_AND;
                        o_legal = !i_funct7b5;
                    end
                    default: begin
                        o_op    = ALU_ADDR;
                        o_legal = 1'b0;
                    end
                endcase
            end
            default: begin
                o_op    = ALU_ADDR;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for ld/sd/beq/add/sub/sll/or/and/ori with retired-instr counter.
// Ports: clock, reset, Opcode, Funct3, Funct7b5, Zero, MemReady in; datapath strobes,
// Operation, InstrCount out; Illegal out only when ILLEGAL_TRAP_EN is defined (trap state).
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [6:0]         Opcode,
    input  logic [2:0]         Funct3,
    input  logic               Funct7b5,
    input  logic               Zero,
    input  logic               MemReady,
    output logic [3:0]         Operation,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [COUNT_W-1:0] InstrCount
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               Illegal
`endif
);

    state_t               r_state;
    logic [3:0]           r_op;
    logic                 r_is_ld;
    logic [COUNT_W-1:0]   r_count;
    logic [3:0]           w_op;
    logic                 w_legal;

    alu_op_decode u_dec (
        .i_opcode   (Opcode),
        .i_funct3   (Funct3),
        .i_funct7b5 (Funct7b5),
        .o_op       (w_op),
        .o_legal    (w_legal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op    <= ALU_ADDR;
            r_is_ld <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (MemReady) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    // Latch the op so ALU_WB can keep driving it.
                    r_op    <= w_op;
                    r_is_ld <= (Opcode == OP_LD);
                    if (!w_legal) begin
`ifdef ILLEGAL_TRAP_EN
                        r_state <= S_TRAP;
`else
                        r_state <= S_FETCH;
`endif
                    end else begin
                        case (Opcode)
                            OP_LD, OP_SD: r_state <= S_MEM_ADDR;
                            OP_R:         r_state <= S_EXEC_R;
                            OP_I:         r_state <= S_EXEC_I;
                            OP_BR:        r_state <= S_BRANCH;
                            default:      r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEM_ADDR: begin
                    r_state <= r_is_ld ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    if (MemReady) r_state <= S_MEM_WB;
                end
                S_MEM_WRITE: begin
                    if (MemReady) begin
                        r_count <= r_count + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_EXEC_R, S_EXEC_I: begin
                    r_state <= S_ALU_WB;
                end
                S_MEM_WB, S_ALU_WB, S_BRANCH: begin
                    r_count <= r_count + 1'b1;
                    r_state <= S_FETCH;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Moore decode; FETCH and BRANCH gate their PC/IR loads on MemReady/Zero.
    always_comb begin
        Operation = ALU_ADDR;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSource  = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RS2;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA   = 1'b1;
                Operation = r_op;
            end
            S_EXEC_I: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                Operation = ALU_ORI;
            end
            S_ALU_WB: begin
                RegWrite  = 1'b1;
                Operation = r_op;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                Operation = ALU_BEQ;
                PCSource  = 1'b1;
                PCWrite   = Zero;
            end
            default: begin
                Operation = ALU_ADDR;
            end
        endcase
    end

    assign InstrCount = r_count;

`ifdef ILLEGAL_TRAP_EN
    assign Illegal = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// A second instance with a 2-bit counter exercises the counter wrap.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  Opcode;
    logic [2:0]  Funct3;
    logic        Funct7b5;
    logic        Zero;
    logic        MemReady;
    logic [3:0]  Operation;
    logic        IRWrite, PCWrite, PCSource, IorD, MemRead, MemWrite;
    logic        RegWrite, MemtoReg, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [31:0] InstrCount;
    logic [3:0]  Operation2;
    logic        IRWrite2, PCWrite2, PCSource2, IorD2, MemRead2, MemWrite2;
    logic        RegWrite2, MemtoReg2, ALUSrcA2;
    logic [1:0]  ALUSrcB2;
    logic [1:0]  InstrCount2;
`ifdef ILLEGAL_TRAP_EN
    logic        Illegal, Illegal2;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clock = ~clock;

    multicycle_control #(.COUNT_W(32)) dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Funct3(Funct3),
        .Funct7b5(Funct7b5), .Zero(Zero), .MemReady(MemReady),
        .Operation(Operation), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .InstrCount(InstrCount)
`ifdef ILLEGAL_TRAP_EN
        , .Illegal(Illegal)
`endif
    );

    multicycle_control #(.COUNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Funct3(Funct3),
        .Funct7b5(Funct7b5), .Zero(Zero), .MemReady(MemReady),
        .Operation(Operation2), .IRWrite(IRWrite2), .PCWrite(PCWrite2),
        .PCSource(PCSource2), .IorD(IorD2), .MemRead(MemRead2),
        .MemWrite(MemWrite2), .RegWrite(RegWrite2), .MemtoReg(MemtoReg2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .InstrCount(InstrCount2)
`ifdef ILLEGAL_TRAP_EN
        , .Illegal(Illegal2)
`endif
    );

    logic [14:0] w_obs;
    assign w_obs = {Operation, IRWrite, PCWrite, PCSource, IorD, MemRead,
                    MemWrite, RegWrite, MemtoReg, ALUSrcA, ALUSrcB};

    // Expected strobe vector, same packing as w_obs.
    function automatic logic [14:0] v(
        input logic [3:0] op, input logic irw, input logic pcw,
        input logic pcs, input logic iord, input logic mr, input logic mw,
        input logic rw, input logic m2r, input logic asa, input logic [1:0] asb);
        return {op, irw, pcw, pcs, iord, mr, mw, rw, m2r, asa, asb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt"}, InstrCount, 32'(exp_cnt));
        chk({tag, "_cnt2"}, 32'(InstrCount2), 32'(exp_cnt % 4));
    endtask

    // Starts and ends in FETCH with MemReady = 1.
    task automatic run_alu(input string tag, input logic [6:0] opc,
                           input logic [2:0] f3, input logic b5,
                           input logic [3:0] eop);
        Opcode = opc; Funct3 = f3; Funct7b5 = b5;
        tick();
        chk({tag, "_dec"}, 32'(w_obs), 32'(v(4'd0,0,0,0,0,0,0,0,0,0,2'b10)));
        tick();
        if (opc == 7'b0010011)
            chk({tag, "_exe"}, 32'(w_obs), 32'(v(eop,0,0,0,0,0,0,0,0,1,2'b10)));
        else
            chk({tag, "_exe"}, 32'(w_obs), 32'(v(eop,0,0,0,0,0,0,0,0,1,2'b00)));
        tick();
        chk({tag, "_wb"}, 32'(w_obs), 32'(v(eop,0,0,0,0,0,0,1,0,0,2'b00)));
        tick();
        exp_cnt++;
        chk({tag, "_fetch"}, 32'(w_obs), 32'(v(4'd0,1,1,0,0,1,0,0,0,0,2'b01)));
        chk_cnt(tag);
    endtask

    task automatic run_illegal(input string tag, input logic [6:0] opc,
                               input logic [2:0] f3, input logic b5);
        Opcode = opc; Funct3 = f3; Funct7b5 = b5;
        tick();
        chk({tag, "_dec"}, 32'(w_obs), 32'(v(4'd0,0,0,0,0,0,0,0,0,0,2'b10)));
        tick();
`ifdef ILLEGAL_TRAP_EN
        chk({tag, "_trap"}, 32'(w_obs), 32'(v(4'd0,0,0,0,0,0,0,0,0,0,2'b00)));
        chk({tag, "_ill"}, 32'(Illegal), 32'd1);
        tick();
        tick();
        chk({tag, "_ill2"}, 32'(Illegal), 32'd1);
        chk_cnt(tag);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        exp_cnt = 0;
        chk({tag, "_ill_clr"}, 32'(Illegal), 32'd0);
`else
        chk({tag, "_fetch"}, 32'(w_obs), 32'(v(4'd0,1,1,0,0,1,0,0,0,0,2'b01)));
`endif
        chk_cnt(tag);
    endtask

    initial begin
        reset = 1'b1; MemReady = 1'b0; Zero = 1'b0;
        Opcode = 7'b0110011; Funct3 = 3'b000; Funct7b5 = 1'b0;
        #2;
        chk("rst_out", 32'(w_obs), 32'(v(4'd0,0,0,0,0,1,0,0,0,0,2'b01)));
        chk_cnt("rst");
        @(negedge clock);
        reset = 1'b0;
        MemReady = 1'b1;
        #1;
        chk("fetch_rdy", 32'(w_obs), 32'(v(4'd0,1,1,0,0,1,0,0,0,0,2'b01)));

        // add x3,x1,x2
        run_alu("add", 7'b0110011, 3'b000, 1'b0, 4'b0010);

        // ld with three stalled MEM_READ cycles: 8 cycles in total
        Opcode = 7'b0000011; Funct3 = 3'b011;
        tick();
        chk("ld_dec", 32'(w_obs), 32'(v(4'd0,0,0,0,0,0,0,0,0,0,2'b10)));
        tick();
        chk("ld_addr", 32'(w_obs), 32'(v(4'd0,0,0,0,0,0,0,0,0,1,2'b10)));
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ld_mrd", 32'(w_obs), 32'(v(4'd0,0,0,0,1,1,0,0,0,0,2'b00)));
        end
        MemReady = 1'b1;
        tick();
        chk("ld_wb", 32'(w_obs), 32'(v(4'd0,0,0,0,0,0,0,1,1,0,2'b00)));
        chk_cnt("ld_wb");
        tick();
        exp_cnt++;
        chk("ld_fetch", 32'(w_obs), 32'(v(4'd0,1,1,0,0,1,0,0,0,0,2'b01)));
        chk_cnt("ld");

        // beq taken then not taken
        Opcode = 7'b1100011; Funct3 = 3'b000; Zero = 1'b1;
        tick();
        tick();
        chk("beq_t", 32'(w_obs), 32'(v(4'b0001,0,1,1,0,0,0,0,0,1,2'b00)));
        tick();
        exp_cnt++;
        chk_cnt("beq_t");
        Zero = 1'b0;
        tick();
        tick();
        chk("beq_nt", 32'(w_obs), 32'(v(4'b0001,0,0,1,0,0,0,0,0,1,2'b00)));
        tick();
        exp_cnt++;
        chk_cnt("beq_nt");

        // sd completes with MemReady high
        Opcode = 7'b0100011; Funct3 = 3'b011;
        tick();
        tick();
        chk("sd_addr", 32'(w_obs), 32'(v(4'd0,0,0,0,0,0,0,0,0,1,2'b10)));
        tick();
        chk("sd_mw", 32'(w_obs), 32'(v(4'd0,0,0,0,1,0,1,0,0,0,2'b00)));
        chk_cnt("sd_mw");
        tick();
        exp_cnt++;
        chk_cnt("sd");

        run_alu("sub", 7'b0110011, 3'b000, 1'b1, 4'b0011);
        run_alu("sll", 7'b0110011, 3'b001, 1'b0, 4'b0100);
        run_alu("or",  7'b0110011, 3'b110, 1'b0, 4'b0101);
        run_alu("and", 7'b0110011, 3'b111, 1'b0, 4'b0110);
        run_alu("ori", 7'b0010011, 3'b110, 1'b0, 4'b0111);

        run_illegal("ill_f3", 7'b0110011, 3'b010, 1'b0);
        run_illegal("ill_sllb5", 7'b0110011, 3'b001, 1'b1);
        run_illegal("ill_op", 7'b1111111, 3'b000, 1'b0);

        // reset asserted while stalled in MEM_WRITE
        Opcode = 7'b0100011; Funct3 = 3'b011;
        tick();
        tick();
        MemReady = 1'b0;
        tick();
        chk("rmw_mw", 32'(w_obs), 32'(v(4'd0,0,0,0,1,0,1,0,0,0,2'b00)));
        tick();
        chk("rmw_hold", 32'(w_obs), 32'(v(4'd0,0,0,0,1,0,1,0,0,0,2'b00)));
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        chk("rmw_rst", 32'(w_obs), 32'(v(4'd0,0,0,0,0,1,0,0,0,0,2'b01)));
        chk_cnt("rmw_rst");
        tick();
        chk_cnt("rmw_hold_rst");
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
